// File: rtl/rf_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_mp_if
// Description : Bus bundle for the multi-read-port register file: write port,
//               packed read ports and the debug scan channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
);
    logic                  we;
    logic                  wp;
    logic [AW-1:0]         wa;
    logic [XLEN-1:0]       wd;
    logic [NRP*AW-1:0]     ra;
    logic [NRP*XLEN-1:0]   rd;
    logic                  scan_en;
    logic [AW-1:0]         scan_idx;
    logic [XLEN-1:0]       scan_data;
    logic                  scan_valid;
    logic                  scan_wrap;

    // Decode/writeback/display side
    modport master (
        output we, wp, wa, wd, ra, scan_en,
        input  rd, scan_idx, scan_data, scan_valid, scan_wrap
    );

    // Register file side
    modport slave (
        input  we, wp, wa, wd, ra, scan_en,
        output rd, scan_idx, scan_data, scan_valid, scan_wrap
    );
endinterface
`default_nettype wire

// File: rtl/rf_mp.sv
`default_nettype none
// ============================================================================
// Module      : rf_mp
// Description : Parametrised register file with NRP combinational read ports,
//               optional write-to-read bypass, write protect and an
//               autonomous debug scan channel that walks every register.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_mp #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int AW        = 5,
    parameter int NRP       = 2,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 0,
    parameter int SCAN_DIV  = 4
) (
    input  wire logic   clk,
    input  wire logic   rstn,
    rf_mp_if.slave      bus
);
    localparam int              DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [AW:0]     NREG_W   = (AW+1)'(NREG);
    localparam logic [AW-1:0]   IDX_LAST = AW'(NREG - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Storage is sized to the full address space so any wa/ra indexes it
    // safely; rows at or above NREG are never written and never read out.
    logic [XLEN-1:0] rf_q [2**AW];

    logic            w_wr_acc;
    logic [XLEN-1:0] w_scan_rd;

    logic [0:0]      state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [AW-1:0]   scan_idx_q, scan_idx_d;
    logic [XLEN-1:0] scan_data_q, scan_data_d;
    logic            scan_valid_q, scan_valid_d;
    logic            scan_wrap_q, scan_wrap_d;

    // A write lands only outside reset, unprotected, to a real non-zero register
    assign w_wr_acc = rstn && bus.we && !bus.wp && (bus.wa != '0)
                      && ({1'b0, bus.wa} < NREG_W);

    // Register array: reset image per INIT_MODE, then accepted writes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2**AW; i++) begin
                rf_q[i] <= (INIT_MODE == 0 && i < NREG) ? XLEN'(i) : '0;
            end
        end else if (w_wr_acc) begin
            rf_q[bus.wa] <= bus.wd;
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;

        assign w_ra = bus.ra[k*AW +: AW];

        // Read port k: zero register / out of range, then bypass, then array
        always_comb begin
            w_rd = rf_q[w_ra];
            if (w_ra == '0 || {1'b0, w_ra} >= NREG_W) begin
                w_rd = '0;
            end else if (BYPASS != 0 && w_wr_acc && bus.wa == w_ra) begin
                w_rd = bus.wd;
            end
        end

        assign bus.rd[k*XLEN +: XLEN] = w_rd;
    end

    // Scan read never bypasses, so a same-cycle write shows on the next capture
    always_comb begin
        w_scan_rd = rf_q[scan_idx_q];
        if (scan_idx_q == '0 || {1'b0, scan_idx_q} >= NREG_W) begin
            w_scan_rd = '0;
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan FSM next state: scan_en alone decides RUN vs IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.scan_en)  state_d = ST_RUN;
            ST_RUN:  if (!bus.scan_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan outputs: capture and step on every cycle that is (or enters) RUN;
    // leaving RUN clears the divider and valid but keeps the index.
    always_comb begin
        div_d        = '0;
        scan_idx_d   = scan_idx_q;
        scan_data_d  = scan_data_q;
        scan_valid_d = 1'b0;
        scan_wrap_d  = 1'b0;
        if (state_d == ST_RUN) begin
            scan_data_d  = w_scan_rd;
            scan_valid_d = 1'b1;
            if (div_q == DIV_LAST) begin
                if (scan_idx_q == IDX_LAST) begin
                    scan_idx_d  = '0;
                    scan_wrap_d = 1'b1;
                end else begin
                    scan_idx_d  = scan_idx_q + AW'(1);
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    // Scan datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_q        <= '0;
            scan_idx_q   <= '0;
            scan_data_q  <= '0;
            scan_valid_q <= 1'b0;
            scan_wrap_q  <= 1'b0;
        end else begin
            div_q        <= div_d;
            scan_idx_q   <= scan_idx_d;
            scan_data_q  <= scan_data_d;
            scan_valid_q <= scan_valid_d;
            scan_wrap_q  <= scan_wrap_d;
        end
    end

    assign bus.scan_idx   = scan_idx_q;
    assign bus.scan_data  = scan_data_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.scan_wrap  = scan_wrap_q;

endmodule
`default_nettype wire
